// File: rtl/vu_vmu_ld_elem_seq.sv
// vu_vmu_ld_elem_seq: unit-stride load element sequencer for the VMU.
// Accepts one load command, buffers aligned 128-bit response lines and walks
// the byte/half/word/dword selector one element per cycle into a one-entry
// writeback register tagged with the element index.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   cmd_val/cmd_rdy, cmd_*            load command (vlen, typ, signext, addr_lsb)
//   line_val/line_rdy, line_data      aligned 16-byte memory response line
//   sel_bhwd_sel, sel_signext,
//   sel_addr_lsb, sel_din, sel_dout   external element selector interface
//   wb_val/wb_rdy, wb_data, wb_idx    element writeback toward the VXU
//   done                              pulse when the last element enters wb
module vu_vmu_ld_elem_seq #(
    parameter int VLEN_SZ = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    input  logic [VLEN_SZ-1:0] cmd_vlen,
    input  logic [1:0]         cmd_typ,
    input  logic               cmd_signext,
    input  logic [3:0]         cmd_addr_lsb,
    input  logic               line_val,
    output logic               line_rdy,
    input  logic [127:0]       line_data,
    output logic [1:0]         sel_bhwd_sel,
    output logic               sel_signext,
    output logic [3:0]         sel_addr_lsb,
    output logic [127:0]       sel_din,
    input  logic [63:0]        sel_dout,
    output logic               wb_val,
    input  logic               wb_rdy,
    output logic [63:0]        wb_data,
    output logic [VLEN_SZ-1:0] wb_idx,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, FILL, EXTRACT} state_t;

    state_t             state, state_nx;
    logic [1:0]         typ;
    logic               signext;
    logic [VLEN_SZ-1:0] vlen, count;
    logic [3:0]         offset;
    logic [127:0]       line_buf;
    logic               cmd_fire, line_fire, fire, last;
    logic [4:0]         offset_sum;
    logic [63:0]        ext_data;

    assign cmd_rdy      = state == IDLE;
    assign line_rdy     = state == FILL;
    assign cmd_fire     = cmd_val & cmd_rdy;
    assign line_fire    = line_val & line_rdy;
    assign fire         = (state == EXTRACT) & (!wb_val | wb_rdy);
    assign last         = count == vlen - VLEN_SZ'(1);
    // bit 4 is the carry out of the line: the next element lives in a new line
    assign offset_sum   = {1'b0, offset} + (5'd1 << typ);
    assign sel_bhwd_sel = typ;
    // the selector's flag means zero-extend, hence the inversion
    assign sel_signext  = ~signext;
    assign sel_addr_lsb = offset;
    assign sel_din      = line_buf;
    // words come back from the selector unextended; narrower types are already extended
    assign ext_data     = typ == 2'b10 ? (signext ? {{32{sel_dout[31]}}, sel_dout[31:0]}
                                                  : {32'd0, sel_dout[31:0]})
                                       : sel_dout;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_vlen != '0) state_nx = FILL;
            FILL:    if (line_fire) state_nx = EXTRACT;
            EXTRACT: if (fire) state_nx = last ? IDLE : offset_sum[4] ? FILL : EXTRACT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            typ      <= '0;
            signext  <= 1'b0;
            vlen     <= '0;
            count    <= '0;
            offset   <= '0;
            line_buf <= '0;
            wb_val   <= 1'b0;
            wb_data  <= '0;
            wb_idx   <= '0;
            done     <= 1'b0;
        end else begin
            if (cmd_fire) begin
                typ     <= cmd_typ;
                signext <= cmd_signext;
                vlen    <= cmd_vlen;
                count   <= '0;
                // misaligned start offsets are rounded down to the element size
                offset  <= cmd_addr_lsb & ~((4'd1 << cmd_typ) - 4'd1);
            end
            if (line_fire) line_buf <= line_data;
            if (fire) begin
                wb_data <= ext_data;
                wb_idx  <= count;
                count   <= count + VLEN_SZ'(1);
                offset  <= offset_sum[3:0];
            end
            wb_val <= fire | (wb_val & ~wb_rdy);
            done   <= (cmd_fire & (cmd_vlen == '0)) | (fire & last);
        end
endmodule

// File: tb/tb_vu_vmu_ld_elem_seq.sv
// tb_vu_vmu_ld_elem_seq: self-checking bench for the load element sequencer
module tb_vu_vmu_ld_elem_seq;
    localparam int VLEN_SZ = 11;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_val, cmd_rdy, cmd_signext;
    logic [VLEN_SZ-1:0] cmd_vlen;
    logic [1:0]         cmd_typ;
    logic [3:0]         cmd_addr_lsb;
    logic               line_val, line_rdy;
    logic [127:0]       line_data;
    logic [1:0]         sel_bhwd_sel;
    logic               sel_signext;
    logic [3:0]         sel_addr_lsb;
    logic [127:0]       sel_din, sh;
    logic [63:0]        sel_dout;
    logic               wb_val, wb_rdy, done;
    logic [63:0]        wb_data;
    logic [VLEN_SZ-1:0] wb_idx;

    int checks = 0, errors = 0;
    logic [7:0] mem [0:1023];
    int lptr, cycle, hold;
    logic pend_cmd, rnd_rdy, stall_arm, rst_done;
    int got_n, line_hs_n, done_n, rdy_seen, wbv_seen, acc_cyc, done_cyc;
    logic [63:0] got_data [0:63];
    logic [63:0] snap_data;
    logic [VLEN_SZ-1:0] snap_idx;
    logic [3:0] snap_off;
    int c_vlen, c_typ, c_off;
    logic c_sx;

    vu_vmu_ld_elem_seq #(.VLEN_SZ(VLEN_SZ)) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_vlen(cmd_vlen), .cmd_typ(cmd_typ),
        .cmd_signext(cmd_signext), .cmd_addr_lsb(cmd_addr_lsb),
        .line_val(line_val), .line_rdy(line_rdy), .line_data(line_data),
        .sel_bhwd_sel(sel_bhwd_sel), .sel_signext(sel_signext), .sel_addr_lsb(sel_addr_lsb),
        .sel_din(sel_din), .sel_dout(sel_dout),
        .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_idx(wb_idx), .done(done)
    );

    always #5 clk = ~clk;

    // selector: sel_signext high means zero-extend; words return with junk upper half
    assign sh = sel_din >> {sel_addr_lsb, 3'b000};
    always_comb begin
        sel_dout = sh[63:0];
        if (sel_bhwd_sel == 2'b00) sel_dout = sel_signext ? {56'd0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]};
        if (sel_bhwd_sel == 2'b01) sel_dout = sel_signext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
        if (sel_bhwd_sel == 2'b10) sel_dout = {32'hA5A5_A5A5, sh[31:0]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [127:0] line_of(input int k);
        logic [127:0] l = '0;
        if (k < 64) for (int j = 0; j < 16; j++) l[8*j +: 8] = mem[16*k + j];
        return l;
    endfunction

    // element i sits in the concatenated line byte stream at c_off + i*size
    function automatic logic [63:0] exp_elem(input int i);
        int sz = 1 << c_typ;
        int p = c_off + i * sz;
        logic [63:0] v = '0;
        for (int b = 0; b < sz; b++) v[8*b +: 8] = mem[p + b];
        if (c_typ != 3 && c_sx && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        return v;
    endfunction

    task automatic rand_mem();
        for (int j = 0; j < 1024; j++) mem[j] = 8'($urandom);
    endtask

    task automatic put32(input int a, input logic [31:0] v);
        for (int b = 0; b < 4; b++) mem[a + b] = v[8*b +: 8];
    endtask

    task automatic cyc();
        @(negedge clk);
        cmd_val   = pend_cmd;
        line_val  = ($urandom_range(0, 3) != 0);
        line_data = line_of(lptr);
        #1;
        if (stall_arm && wb_val) begin
            stall_arm = 1'b0;
            hold      = 5;
            snap_data = wb_data;
            snap_idx  = wb_idx;
            snap_off  = sel_addr_lsb;
        end else if (hold > 0) begin
            chk("stall_wb_val", 64'(wb_val), 64'd1);
            chk("stall_wb_data", wb_data, snap_data);
            chk("stall_wb_idx", 64'(wb_idx), 64'(snap_idx));
            chk("stall_sel_addr_lsb", 64'(sel_addr_lsb), 64'(snap_off));
        end
        wb_rdy = hold > 0 ? 1'b0 : rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hold > 0) hold--;
        #1;
        if (cmd_val && cmd_rdy) begin
            pend_cmd = 1'b0;
            acc_cyc  = cycle;
        end
        if (line_val && line_rdy) begin
            line_hs_n++;
            lptr++;
        end
        if (line_rdy) rdy_seen++;
        if (wb_val) wbv_seen++;
        if (done) begin
            done_n++;
            done_cyc = cycle;
        end
        if (wb_val && wb_rdy) begin
            if (got_n < c_vlen && got_n < 64) begin
                chk("wb_idx", 64'(wb_idx), 64'(got_n));
                chk("wb_data", wb_data, exp_elem(got_n));
                got_data[got_n] = wb_data;
            end
            got_n++;
        end
        cycle++;
        @(posedge clk);
    endtask

    task automatic run_cmd(input int vlen, input int typ, input logic sx, input int addr, input int rst_at);
        int exp_lines, bound;
        #2;
        c_vlen = vlen; c_typ = typ; c_sx = sx;
        c_off  = addr & ~((1 << typ) - 1);
        got_n = 0; line_hs_n = 0; done_n = 0; rdy_seen = 0; wbv_seen = 0;
        acc_cyc = -100; done_cyc = -1; lptr = 0; rst_done = 1'b0;
        cmd_vlen = VLEN_SZ'(vlen); cmd_typ = 2'(typ); cmd_signext = sx; cmd_addr_lsb = 4'(addr);
        pend_cmd = 1'b1;
        exp_lines = vlen == 0 ? 0 : (c_off + vlen * (1 << typ) + 15) / 16;
        bound = 0;
        while (!(got_n >= vlen && done_n > 0) && bound < 3000) begin
            cyc();
            bound++;
            if (rst_at >= 0) begin
                #2;
                if (wb_val && wb_idx == VLEN_SZ'(rst_at)) begin
                    reset = 1'b1;
                    #1;
                    rst_done = 1'b1;
                    chk("rst_wb_val", 64'(wb_val), 64'd0);
                    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
                    chk("rst_line_rdy", 64'(line_rdy), 64'd0);
                    chk("rst_wb_idx", 64'(wb_idx), 64'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    return;
                end
            end
        end
        if (rst_at >= 0) chk("rst_reached", 64'(rst_done), 64'd1);
        repeat (3) cyc();
        chk("timeout", 64'(bound < 3000), 64'd1);
        chk("elem_count", 64'(got_n), 64'(vlen));
        chk("done_count", 64'(done_n), 64'd1);
        chk("line_handshakes", 64'(line_hs_n), 64'(exp_lines));
        if (vlen == 0) begin
            chk("vlen0_done_latency", 64'(done_cyc - acc_cyc), 64'd1);
            chk("vlen0_line_rdy", 64'(rdy_seen), 64'd0);
            chk("vlen0_wb_val", 64'(wbv_seen), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_val = 1'b0; cmd_vlen = '0; cmd_typ = '0; cmd_signext = 1'b0;
        cmd_addr_lsb = '0; line_val = 1'b0; line_data = '0; wb_rdy = 1'b0;
        pend_cmd = 1'b0; rnd_rdy = 1'b0; stall_arm = 1'b0; hold = 0; lptr = 0; cycle = 0;
        c_vlen = 0; c_typ = 0; c_off = 0; c_sx = 1'b0; got_n = 0;
        #1;
        chk("reset_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("reset_line_rdy", 64'(line_rdy), 64'd0);
        chk("reset_wb_val", 64'(wb_val), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_wb_idx", 64'(wb_idx), 64'd0);
        chk("reset_wb_data", wb_data, 64'd0);
        chk("reset_sel_addr_lsb", 64'(sel_addr_lsb), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        rand_mem();
        for (int j = 0; j < 32; j++) mem[j] = 8'(128 + j);
        run_cmd(20, 0, 1'b1, 0, -1);
        chk("byte_elem0", got_data[0], 64'hFFFF_FFFF_FFFF_FF80);
        chk("byte_elem19", got_data[19], 64'hFFFF_FFFF_FFFF_FF93);

        rand_mem();
        put32(8, 32'h8000_0001); put32(12, 32'h7FFF_FFFF); put32(16, 32'h1234_5678);
        run_cmd(3, 2, 1'b1, 8, -1);
        chk("word_sx_elem0", got_data[0], 64'hFFFF_FFFF_8000_0001);
        chk("word_sx_elem1", got_data[1], 64'h0000_0000_7FFF_FFFF);
        chk("word_sx_elem2", got_data[2], 64'h0000_0000_1234_5678);
        run_cmd(3, 2, 1'b0, 8, -1);
        chk("word_zx_elem0", got_data[0], 64'h0000_0000_8000_0001);
        chk("word_zx_elem2", got_data[2], 64'h0000_0000_1234_5678);

        rand_mem();
        run_cmd(4, 3, 1'b0, 5, -1);

        run_cmd(0, 1, 1'b1, 3, -1);

        rand_mem();
        stall_arm = 1'b1;
        run_cmd(12, 1, 1'b1, 0, -1);
        chk("stall_triggered", 64'(stall_arm), 64'd0);

        rand_mem();
        run_cmd(20, 0, 1'b1, 0, 6);
        rand_mem();
        run_cmd(10, 0, 1'b0, 0, -1);

        rnd_rdy = 1'b1;
        for (int n = 0; n < 12; n++) begin
            rand_mem();
            run_cmd($urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
